// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment scan display path.
//   SEG_BLANK   : active-low segment pattern with every segment (and dp) off
//   DIGIT_BLANK : digit code that the encoder renders as a blank slot
//   bcd_t       : one 4-bit BCD digit as carried through the frame buffers
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  typedef logic [3:0] bcd_t;

endpackage : seg7_pkg

// File: rtl/hex_encoder.sv
// hex_encoder: combinational BCD to active-low 7-segment encoder.
//   digit : in  4  BCD digit, values 10..15 are rendered blank
//   seg   : out 8  active-low segments {dp,g,f,e,d,c,b,a}, dp always off
module hex_encoder
  import seg7_pkg::*;
(
  input  bcd_t       digit,
  output logic [7:0] seg
);

  // Segment lookup; anything outside 0..9 blanks the slot.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule : hex_encoder

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: time-multiplexes NUM_DIGITS BCD digits onto one shared
// 7-segment driver with double-buffered frames and anti-ghost blanking.
//   clk        : in  1             system clock, rising edge
//   rst_n      : in  1             synchronous reset, active-low
//   en         : in  1             1 scan, 0 hold counters with anodes off
//   load_valid : in  1             capture digits_in into the shadow buffer
//   digits_in  : in  4*NUM_DIGITS  digit k at [4k+3:4k], digit 0 rightmost
//   blink      : in  1             blink request (only with SEG_BLINK_EN)
//   seg_out    : out 8             active-low segments {dp,g..a}, registered
//   digit_sel  : out NUM_DIGITS    active-low anodes, one-hot-low or all 1
//   frame_done : out 1             pulse the cycle after a frame completes
// Optional feature: define SEG_BLINK_EN to build the frame-based blink logic.
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_DIV    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blink,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_LIM = SW'(BLANK_CYCLES);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{1'b1}};

  logic [IW-1:0]               idx_q, idx_d;
  logic [SW-1:0]               slot_cnt_q, slot_cnt_d;
  bcd_t [NUM_DIGITS-1:0]       shadow_q, shadow_d;
  bcd_t [NUM_DIGITS-1:0]       active_q, active_d;
  logic [7:0]                  seg_out_q, seg_out_d;
  logic [NUM_DIGITS-1:0]       digit_sel_q, digit_sel_d;
  logic                        frame_done_q, frame_done_d;

  logic                        frame_bound_s;
  logic                        blink_blank_s;
  bcd_t                        cur_digit_s;
  logic [7:0]                  enc_seg_s;

  assign frame_bound_s = en && (idx_q == IDX_LAST) && (slot_cnt_q == SLOT_LAST);
  assign cur_digit_s   = active_q[idx_q];

  hex_encoder u_hex_encoder (
    .digit (cur_digit_s),
    .seg   (enc_seg_s)
  );

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  // Blink phase: counts frame boundaries while blinking, idles cleared otherwise.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!blink) begin
      blink_cnt_d = BW'(0);
      phase_d     = 1'b0;
    end else if (frame_bound_s) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = BW'(0);
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
  end

  assign blink_blank_s = blink && phase_q;
`else
  logic unused_blink_s;
  assign unused_blink_s = blink;
  assign blink_blank_s  = 1'b0;
`endif

  // Next-state: scan counters, frame buffers and the registered pin values.
  always_comb begin
    idx_d        = idx_q;
    slot_cnt_d   = slot_cnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    frame_done_d = frame_bound_s;
    seg_out_d    = SEG_BLANK;
    digit_sel_d  = SEL_OFF;

    if (en) begin
      if (slot_cnt_q == SLOT_LAST) begin
        slot_cnt_d = SW'(0);
        if (idx_q == IDX_LAST) begin
          idx_d = IW'(0);
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        slot_cnt_d = slot_cnt_q + SW'(1);
      end
    end else begin
      slot_cnt_d = slot_cnt_q;
    end

    if (load_valid) begin
      shadow_d = digits_in;
    end else begin
      shadow_d = shadow_q;
    end

    // shadow_d already carries a same-cycle load, which gives the bypass.
    if (frame_bound_s) begin
      active_d = shadow_d;
    end else begin
      active_d = active_q;
    end

    // Anodes stay off at slot start so the previous digit cannot ghost.
    if (!en || (slot_cnt_q < BLANK_LIM) || blink_blank_s) begin
      seg_out_d   = SEG_BLANK;
      digit_sel_d = SEL_OFF;
    end else begin
      seg_out_d   = enc_seg_s;
      digit_sel_d = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q        <= IW'(0);
      slot_cnt_q   <= SW'(0);
      shadow_q     <= {NUM_DIGITS{DIGIT_BLANK}};
      active_q     <= {NUM_DIGITS{DIGIT_BLANK}};
      seg_out_q    <= SEG_BLANK;
      digit_sel_q  <= SEL_OFF;
      frame_done_q <= 1'b0;
`ifdef SEG_BLINK_EN
      blink_cnt_q  <= BW'(0);
      phase_q      <= 1'b0;
`endif
    end else begin
      idx_q        <= idx_d;
      slot_cnt_q   <= slot_cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      seg_out_q    <= seg_out_d;
      digit_sel_q  <= digit_sel_d;
      frame_done_q <= frame_done_d;
`ifdef SEG_BLINK_EN
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
`endif
    end
  end

  assign seg_out    = seg_out_q;
  assign digit_sel  = digit_sel_q;
  assign frame_done = frame_done_q;

endmodule : seg7_scan_controller

// File: tb/tb_seg7_scan_controller.sv
// Self-checking bench for seg7_scan_controller with a small scan geometry
// (4 digits, 4 cycles per slot, 1 blank cycle, blink every 2 frames).
module tb_seg7_scan_controller;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BC = 1;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load_valid;
  logic [15:0] digits_in;
  logic        blink;
  logic [7:0]  seg_out;
  logic [3:0]  digit_sel;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_controller #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC),
    .BLINK_DIV    (BD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load_valid (load_valid),
    .digits_in  (digits_in),
    .blink      (blink),
    .seg_out    (seg_out),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  int          m_idx   = 0;
  int          m_slot  = 0;
  logic [15:0] m_shadow = 16'hFFFF;
  logic [15:0] m_active = 16'hFFFF;
  int          m_bcnt  = 0;
  logic        m_phase = 1'b0;

  function automatic logic [7:0] ref_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0: s = 8'hC0;  4'd1: s = 8'hF9;  4'd2: s = 8'hA4;  4'd3: s = 8'hB0;
      4'd4: s = 8'h99;  4'd5: s = 8'h92;  4'd6: s = 8'h82;  4'd7: s = 8'hF8;
      4'd8: s = 8'h80;  4'd9: s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict outputs from model state and inputs, advance model, compare.
  task automatic step();
    exp_t       e;
    logic       fb;
    logic       blank_all;
    logic [3:0] d;
    fb        = en && (m_idx == ND-1) && (m_slot == SD-1);
    blank_all = 1'b0;
`ifdef SEG_BLINK_EN
    blank_all = blink && m_phase;
`endif
    if (!rst_n) begin
      e.sel = 4'hF; e.seg = 8'hFF; e.fd = 1'b0;
    end else begin
      e.fd = fb;
      if (!en || (m_slot < BC) || blank_all) begin
        e.sel = 4'hF; e.seg = 8'hFF;
      end else begin
        d     = m_active[4*m_idx +: 4];
        e.sel = ~(4'b0001 << m_idx);
        e.seg = ref_seg(d);
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    if (!rst_n) begin
      m_idx = 0; m_slot = 0; m_shadow = 16'hFFFF; m_active = 16'hFFFF;
      m_bcnt = 0; m_phase = 1'b0;
    end else begin
      if (fb) m_active = load_valid ? digits_in : m_shadow;
      if (load_valid) m_shadow = digits_in;
      if (en) begin
        if (m_slot == SD-1) begin
          m_slot = 0;
          m_idx  = (m_idx + 1) % ND;
        end else begin
          m_slot++;
        end
      end
      if (!blink) begin
        m_bcnt = 0; m_phase = 1'b0;
      end else if (fb) begin
        if (m_bcnt == BD-1) begin
          m_bcnt = 0; m_phase = ~m_phase;
        end else begin
          m_bcnt++;
        end
      end
    end
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("digit_sel", {28'd0, digit_sel}, {28'd0, e.sel});
      check_eq("seg_out", {24'd0, seg_out}, {24'd0, e.seg});
      check_eq("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until a frame_done pulse is observed, bounded.
  task automatic wait_fd();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (frame_done) seen = 1'b1;
    end
    check_eq("fd_wait", {31'd0, seen}, 32'd1);
  endtask

  // Called right after a frame boundary: check one frame against fixed patterns.
  task automatic check_frame(input logic [31:0] segs);
    logic [3:0] sel_exp;
    for (int k = 0; k < ND; k++) begin
      step();
      check_eq("blank_sel", {28'd0, digit_sel}, 32'hF);
      step();
      sel_exp = ~(4'b0001 << k);
      check_eq("lit_sel", {28'd0, digit_sel}, {28'd0, sel_exp});
      check_eq("lit_seg", {24'd0, seg_out}, {24'd0, segs[8*k +: 8]});
      step();
      step();
    end
  endtask

  initial begin
    int fdc;
    rst_n = 1'b0; en = 1'b0; load_valid = 1'b0; blink = 1'b0; digits_in = 16'h0000;
    run(3);
    rst_n = 1'b1; en = 1'b1;
    run(20);

    // Basic load and display
    digits_in = 16'h1234; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    wait_fd();
    check_frame(32'hF9A4B099);

    // Mid-frame load must not tear the current frame
    run(5);
    digits_in = 16'h5678; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    wait_fd();
    check_frame(32'h9282F880);

    // Load on the boundary cycle bypasses straight into the next frame
    for (int i = 0; i < 40 && !((m_idx == ND-1) && (m_slot == SD-1)); i++) step();
    digits_in = 16'h9999; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    check_eq("bypass_fd", {31'd0, frame_done}, 32'd1);
    check_frame(32'h90909090);

    // Pause mid-slot; loads still accepted while paused
    run(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      load_valid = (i == 5);
      digits_in  = 16'h4321;
      step();
      check_eq("en0_sel", {28'd0, digit_sel}, 32'hF);
    end
    load_valid = 1'b0;
    en = 1'b1;
    run(20);

    // Non-BCD digit blanks its slot; frame_done once per 16 cycles
    digits_in = 16'h000A; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    wait_fd();
    check_frame(32'hC0C0C0FF);
    fdc = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (frame_done) fdc++;
    end
    check_eq("fd_count", fdc, 32'd2);

    // Blink request, then release
    blink = 1'b1;
    run(16 * 6);
    blink = 1'b0;
    run(20);

    // Reset mid-frame discards everything
    run(5);
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seg7_scan_controller
